// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register: occupancy states and count encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    function automatic logic [1:0] state_count(input state_t s);
        case (s)
            ONE:     return CNT_ONE;
            FULL:    return CNT_FULL;
            default: return CNT_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/reg_en.sv
// WIDTH-bit enabled register with asynchronous active-low reset to RESET_VAL.
module reg_en #(
    parameter int                WIDTH     = 64,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, synchronous flush and bubble output.
// Handshake: a beat moves when valid and ready are both high at a rising edge; ready never depends on valid.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count
);

    state_t           state_q;
    state_t           state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_en;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] skid_q;

    // Every output is a function of registered state only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign count     = state_count(state_q);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = BUBBLE;
        skid_en = 1'b0;
        skid_d  = in_data;
        if (flush) begin
            // main is reloaded with BUBBLE so an empty stage always shows the NOP value.
            state_d = EMPTY;
            main_en = 1'b1;
            main_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                        main_d  = in_data;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        main_en = 1'b1;
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    reg_en #(
        .WIDTH     (WIDTH),
        .RESET_VAL (BUBBLE)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (main_en),
        .d       (main_d),
        .q       (main_q)
    );

    reg_en #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (skid_en),
        .d       (skid_d),
        .q       (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three widths driven in lockstep against a queue-based FIFO model.
module tb_pipe_skid_reg;

    logic clk;
    logic reset_n;
    logic in_valid;
    logic out_ready;
    logic flush;
    logic [127:0] in_data128;
    logic [63:0]  in_data64;
    logic [0:0]   in_data1;

    logic         in_ready64, out_valid64;
    logic [63:0]  out_data64;
    logic [1:0]   count64;
    logic         in_ready1, out_valid1;
    logic [0:0]   out_data1;
    logic [1:0]   count1;
    logic         in_ready128, out_valid128;
    logic [127:0] out_data128;
    logic [1:0]   count128;

    logic [127:0] exp_q[$];
    int n_cmp;
    int n_err;

    assign in_data64 = in_data128[63:0];
    assign in_data1  = in_data128[0:0];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_data(in_data64), .out_valid(out_valid64), .out_ready(out_ready),
        .out_data(out_data64), .flush(flush), .count(count64)
    );

    pipe_skid_reg #(.WIDTH(1), .BUBBLE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .flush(flush), .count(count1)
    );

    pipe_skid_reg #(.WIDTH(128), .BUBBLE({128{1'b1}})) dut128 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready128),
        .in_data(in_data128), .out_valid(out_valid128), .out_ready(out_ready),
        .out_data(out_data128), .flush(flush), .count(count128)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2; flush empties it.
    task automatic model_step();
        int  sz;
        logic in_fire;
        logic out_fire;
        sz = exp_q.size();
        if (flush) begin
            exp_q.delete();
        end else begin
            in_fire  = in_valid && (sz < 2);
            out_fire = (sz > 0) && out_ready;
            if (out_fire) void'(exp_q.pop_front());
            if (in_fire) exp_q.push_back(in_data128);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        logic [127:0] head;
        sz   = exp_q.size();
        head = (sz > 0) ? exp_q[0] : 128'd0;
        chk({tag, ":valid64"},  {127'd0, out_valid64},  {127'd0, sz > 0});
        chk({tag, ":ready64"},  {127'd0, in_ready64},   {127'd0, sz < 2});
        chk({tag, ":count64"},  {126'd0, count64},      128'(sz));
        chk({tag, ":data64"},   {64'd0, out_data64},    (sz > 0) ? {64'd0, head[63:0]} : 128'd0);
        chk({tag, ":valid1"},   {127'd0, out_valid1},   {127'd0, sz > 0});
        chk({tag, ":count1"},   {126'd0, count1},       128'(sz));
        chk({tag, ":data1"},    {127'd0, out_data1},    (sz > 0) ? {127'd0, head[0]} : 128'd1);
        chk({tag, ":ready128"}, {127'd0, in_ready128},  {127'd0, sz < 2});
        chk({tag, ":data128"},  out_data128,            (sz > 0) ? head : {128{1'b1}});
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic r, input logic f, input logic [127:0] d);
        in_valid   = v;
        out_ready  = r;
        flush      = f;
        in_data128 = d;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 128'd0);

        // reset, then idle
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        cycle("idle");

        // streaming
        drive(1'b1, 1'b1, 1'b0, 128'd500);
        cycle("stream0");
        chk("stream0_const", {64'd0, out_data64}, 128'd500);
        drive(1'b1, 1'b1, 1'b0, 128'd1234);
        cycle("stream1");
        chk("stream1_const", {64'd0, out_data64}, 128'd1234);
        drive(1'b1, 1'b1, 1'b0, 128'd7);
        cycle("stream2");
        chk("stream2_const", {64'd0, out_data64}, 128'd7);
        drive(1'b0, 1'b1, 1'b0, 128'd0);
        cycle("stream_drain");

        // stall and skid
        drive(1'b1, 1'b1, 1'b0, 128'd10);
        cycle("stall10");
        drive(1'b1, 1'b0, 1'b0, 128'd11);
        cycle("stall11");
        chk("stall_count", {126'd0, count64}, 128'd2);
        chk("stall_ready", {127'd0, in_ready64}, 128'd0);
        drive(1'b1, 1'b0, 1'b0, 128'd12);
        cycle("stall12_held");
        chk("stall_head", {64'd0, out_data64}, 128'd10);
        drive(1'b1, 1'b1, 1'b0, 128'd12);
        cycle("recover1");
        chk("recover1_data", {64'd0, out_data64}, 128'd11);
        chk("recover1_ready", {127'd0, in_ready64}, 128'd1);
        cycle("recover2");
        chk("recover2_data", {64'd0, out_data64}, 128'd12);
        drive(1'b0, 1'b1, 1'b0, 128'd0);
        cycle("recover_drain");

        // flush from FULL
        drive(1'b1, 1'b0, 1'b0, 128'd20);
        cycle("flush_fill20");
        drive(1'b1, 1'b0, 1'b0, 128'd21);
        cycle("flush_fill21");
        drive(1'b1, 1'b1, 1'b1, 128'd99);
        cycle("flush");
        chk("flush_count", {126'd0, count64}, 128'd0);
        chk("flush_data", {64'd0, out_data64}, 128'd0);
        drive(1'b0, 1'b1, 1'b0, 128'd0);
        cycle("flush_after");
        chk("flush_no99", {127'd0, out_data64 == 64'd99}, 128'd0);

        // asynchronous reset while holding an entry
        drive(1'b1, 1'b0, 1'b0, 128'hDEAD);
        cycle("dead_load");
        drive(1'b0, 1'b0, 1'b0, 128'd0);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        cycle("post_reset");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  1'((i % 100) < 50 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0)),
                  1'($urandom_range(0, 24) == 0),
                  {$urandom, $urandom, $urandom, $urandom});
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
